// File: rtl/lfsr32.sv
// Free-running 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1) whose registered state is the output.
// Power-up, reset and recovery from the all-zero lock-up state all load the seed.
module lfsr32 #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] TAPS  = 32'h8020_0003,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] rnd
);

  // A zero seed would park the register in the lock-up state, so it is replaced by 1.
  localparam logic [WIDTH-1:0] safeseed = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state = safeseed;
  logic             fb;

  assign fb  = ^(state & TAPS);
  assign rnd = state;

  // Priority: reset, then the lock-up guard, then the normal shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= safeseed;
    end else if (state == '0) begin
      state <= safeseed;
    end else begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: tb/tb_lfsr32.sv
// Self-checking bench for lfsr32: known sequences, reset behaviour, lock-up recovery
// and randomized reset pulses compared against an arithmetic polynomial model.
module tb_lfsr32;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rnd;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model;
  logic [31:0] knownSeq [5];
  int          sawZero;
  int          sawSeed;

  lfsr32 dut (
    .clock (clock),
    .reset (reset),
    .rnd   (rnd)
  );

  always #5 clock = ~clock;

  // Reference successor: multiply by two modulo 2^32, add the parity of the tapped bits.
  function automatic logic [31:0] refNext(input logic [31:0] cur, input logic rst);
    logic [31:0] doubled;
    int          ones;
    if (rst || cur == 32'h0) return SEED;
    doubled = cur * 2;
    ones    = $countones(cur & TAPS);
    return doubled + 32'(ones % 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive reset for one clock edge, advance the model and compare at the falling edge.
  task automatic applyStimulus(input logic rst, input string tag);
    reset = rst;
    @(posedge clock);
    @(negedge clock);
    model = refNext(model, rst);
    checkOutput(tag, rnd, model);
  endtask

  task automatic checkKnownSeq(input string tag);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, tag);
      checkOutput({tag, "_const"}, rnd, knownSeq[i]);
    end
  endtask

  initial begin
    knownSeq[0] = 32'h0000_0003;
    knownSeq[1] = 32'h0000_0006;
    knownSeq[2] = 32'h0000_000D;
    knownSeq[3] = 32'h0000_001B;
    knownSeq[4] = 32'h0000_0036;

    // Power-up value with no reset ever applied.
    #1;
    model = SEED;
    checkOutput("powerup", rnd, 32'h0000_0001);
    checkKnownSeq("powerup_seq");

    // Single reset edge then release.
    applyStimulus(1'b1, "reset_edge");
    checkOutput("reset_edge_const", rnd, 32'h0000_0001);
    checkKnownSeq("post_reset_seq");

    // Run 80 cycles, hold reset for 16, then the sequence must repeat.
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, "run80");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, "reset_hold");
      checkOutput("reset_hold_const", rnd, 32'h0000_0001);
    end
    checkKnownSeq("reset_hold_seq");

    // Upset the register into the all-zero state.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, "pre_force");
    force dut.state = 32'h0;
    #1;
    release dut.state;
    #1;
    checkOutput("forced_zero", rnd, 32'h0);
    model = 32'h0;
    applyStimulus(1'b0, "lockup_recover");
    checkOutput("lockup_recover_const", rnd, 32'h0000_0001);
    applyStimulus(1'b0, "lockup_next");
    checkOutput("lockup_next_const", rnd, 32'h0000_0003);

    // Randomized reset pulses scattered through a long run.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, "random");
    end

    // Free run after reset: never zero and never back to the seed.
    applyStimulus(1'b1, "freerun_reset");
    sawZero = 0;
    sawSeed = 0;
    for (int i = 0; i < 20000; i++) begin
      applyStimulus(1'b0, "freerun");
      if (rnd == 32'h0) sawZero++;
      if (rnd == SEED) sawSeed++;
    end
    checkOutput("freerun_zero_count", 32'(sawZero), 32'h0);
    checkOutput("freerun_seed_count", 32'(sawSeed), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
